// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and bus geometry for the APB arbiter
package apb_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: 2-way round-robin grant with a last-granted pointer
module rr_arbiter
    import apb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] gnt
);
    logic last;

    // Requester 0 wins a tie only when requester 1 was granted most recently
    always_comb gnt = (req[0] && (!req[1] || last)) ? 2'b01 : req[1] ? 2'b10 : 2'b00;

    // Pointer moves at grant time; reset favours requester 0 for the first tie
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (take && |req)
            last <= gnt[1];
    end
endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: two requesters sharing one APB master; optional ACCESS timeout via APB_TIMEOUT_EN
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       req_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PREADY
);
    state_t             state, state_n;
    logic [NUM_REQ-1:0] eligible, gnt;
    logic               owner;
    logic               finish, fail;

    // A requester whose done pulse is showing cannot be re-granted in that same cycle
    assign eligible = req_valid & ~req_done;
    assign finish   = state == ACCESS && (PREADY || fail);
    assign PSEL     = state != IDLE;
    assign PENABLE  = state == ACCESS;

    rr_arbiter u_rr (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .req   (eligible),
        .take  (state == IDLE),
        .gnt   (gnt)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waits;

    assign fail = state == ACCESS && !PREADY && waits == CNT_W'(TIMEOUT_CYCLES - 1);

    // Count stalled ACCESS cycles; restart on every new SETUP
    always_ff @(posedge PCLK) begin
        if (!PRESETn || state_n == SETUP)
            waits <= '0;
        else if (state == ACCESS && !PREADY)
            waits <= waits + 1'b1;
    end
`else
    assign fail = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK) begin
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |eligible ? SETUP : IDLE;
            SETUP:   state_n = ACCESS;
            ACCESS:  state_n = finish ? IDLE : ACCESS;
            default: state_n = IDLE;
        endcase
    end

    // Capture the granted payload in IDLE and produce the registered completion
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            owner     <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            req_done  <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
        end else begin
            if (state == IDLE && |eligible) begin
                owner  <= gnt[1];
                PWRITE <= |(gnt & req_write);
                PADDR  <= gnt[0] ? req_addr[ADDR_W-1:0]  : req_addr[2*ADDR_W-1:ADDR_W];
                PWDATA <= gnt[0] ? req_wdata[DATA_W-1:0] : req_wdata[2*DATA_W-1:DATA_W];
            end
            req_done  <= finish ? (owner ? 2'b10 : 2'b01) : 2'b00;
            req_rdata <= (finish && !PWRITE && !fail) ? PRDATA : '0;
            req_err   <= finish && fail;
        end
    end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: randomized requester/slave stimulus against a transaction-order scoreboard
module tb_apb_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY = 1'b0;

    typedef struct {
        int          id;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int last = 1;
    int ready_mode = 0;
    int low_run = 0;

    always #5 PCLK = ~PCLK;

    apb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    function automatic logic [31:0] rdv(input logic [31:0] a);
        return a == 32'h4 ? 32'h11 : a == 32'h8 ? 32'h22 : a ^ 32'hC3A5_1F0E;
    endfunction

    assign PRDATA = rdv(PADDR);

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
        for (int i = 0; i < 2; i++)
            if (req_done[i]) req_valid[i] = 1'b0;
        if (ready_mode == 1)
            PREADY = 1'b1;
        else if (ready_mode == 2)
            PREADY = 1'b0;
        else begin
            PREADY = low_run >= 3 ? 1'b1 : ($urandom_range(0, 1) == 1);
            low_run = PREADY ? 0 : low_run + 1;
        end
    endtask

    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] wd);
        req_write[i] = w;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = wd;
        req_valid[i] = 1'b1;
    endtask

    function automatic exp_t mk(input int i, input logic w, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e = '{i, w, a, wd, w ? 32'h0 : rdv(a), 1'b0};
        return e;
    endfunction

    task automatic drain(input string n);
        for (int c = 0; c < 200 && req_valid != 0; c++) tick();
        chk(n, 32'(req_valid), 32'h0);
        req_valid = '0;
    endtask

    task automatic round(input logic [1:0] m, input logic [1:0] w, input logic [63:0] a, input logic [63:0] wd);
        int f;
        tick();
        for (int i = 0; i < 2; i++)
            if (m[i]) issue(i, w[i], a[i*32 +: 32], wd[i*32 +: 32]);
        if (m == 2'b11) begin
            f = last == 1 ? 0 : 1;
            q.push_back(mk(f, w[f], a[f*32 +: 32], wd[f*32 +: 32]));
            q.push_back(mk(1 - f, w[1-f], a[(1-f)*32 +: 32], wd[(1-f)*32 +: 32]));
            last = 1 - f;
        end else begin
            f = m[1] ? 1 : 0;
            q.push_back(mk(f, w[f], a[f*32 +: 32], wd[f*32 +: 32]));
            last = f;
        end
        drain("round_complete");
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_psel"}, 32'(PSEL), 32'h0);
        chk({n, "_penable"}, 32'(PENABLE), 32'h0);
        chk({n, "_pwrite"}, 32'(PWRITE), 32'h0);
        chk({n, "_paddr"}, PADDR, 32'h0);
        chk({n, "_pwdata"}, PWDATA, 32'h0);
        chk({n, "_done"}, 32'(req_done), 32'h0);
        chk({n, "_rdata"}, req_rdata, 32'h0);
        chk({n, "_err"}, 32'(req_err), 32'h0);
    endtask

    // Monitor: protocol checks and scoreboard pops, sampled mid-cycle
    logic        p_access = 1'b0, p_accept = 1'b0, p_psel = 1'b0, p_write = 1'b0;
    logic [1:0]  p_done = '0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    always @(negedge PCLK) begin
        exp_t e;
        if (p_accept) chk("done_after_ready", 32'(req_done != 0), 32'h1);
        if (req_done != 0) begin
            chk("done_prev_access", 32'(p_access), 32'h1);
            chk("done_onehot", 32'($onehot0(req_done)), 32'h1);
            chk("done_back_to_back", 32'(req_done & p_done), 32'h0);
            if (q.size() == 0)
                chk("done_unexpected", 32'(req_done), 32'h0);
            else begin
                e = q.pop_front();
                chk("done_id", 32'(req_done), e.id == 0 ? 32'h1 : 32'h2);
                chk("done_rdata", req_rdata, e.rd);
                chk("done_err", 32'(req_err), 32'(e.err));
            end
        end
        if (PSEL && !PENABLE) begin
            if (q.size() == 0)
                chk("setup_unexpected", 32'(PSEL), 32'h0);
            else begin
                chk("setup_paddr", PADDR, q[0].a);
                chk("setup_pwrite", 32'(PWRITE), 32'(q[0].w));
                chk("setup_pwdata", PWDATA, q[0].wd);
            end
        end
        if (PSEL && PENABLE) begin
            chk("access_prev_psel", 32'(p_psel), 32'h1);
            chk("access_paddr_stable", PADDR, p_addr);
            chk("access_pwdata_stable", PWDATA, p_wdata);
            chk("access_pwrite_stable", 32'(PWRITE), 32'(p_write));
        end
        p_access = PSEL && PENABLE && PRESETn;
        p_accept = PSEL && PENABLE && PREADY && PRESETn;
        p_psel   = PSEL;
        p_done   = req_done;
        p_addr   = PADDR;
        p_wdata  = PWDATA;
        p_write  = PWRITE;
    end

    initial begin
        int acc;
        PRESETn = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        PRESETn = 1'b1;

        // Simultaneous reads after reset: r0 first, then r1; twice to show alternation
        round(2'b11, 2'b00, {32'h8, 32'h4}, 64'h0);
        round(2'b11, 2'b00, {32'h8, 32'h4}, 64'h0);

        // Zero-wait write latency
        tick();
        ready_mode = 1;
        issue(0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        q.push_back(mk(0, 1'b1, 32'h10, 32'hA5A5_A5A5));
        last = 0;
        tick();
        chk("lat_c1_psel", 32'(PSEL), 32'h1);
        chk("lat_c1_penable", 32'(PENABLE), 32'h0);
        tick();
        chk("lat_c2_psel", 32'(PSEL), 32'h1);
        chk("lat_c2_penable", 32'(PENABLE), 32'h1);
        tick();
        chk("lat_c3_done", 32'(req_done), 32'h1);
        chk("lat_c3_err", 32'(req_err), 32'h0);
        chk("lat_c3_psel", 32'(PSEL), 32'h0);
        tick();
        chk("lat_c4_done", 32'(req_done), 32'h0);
        ready_mode = 0;

        // Reset while stalled in ACCESS abandons the transfer, then it restarts
        tick();
        ready_mode = 2;
        issue(0, 1'b0, 32'h100, 32'h0);
        q.push_back(mk(0, 1'b0, 32'h100, 32'h0));
        for (int c = 0; c < 20 && !(PSEL && PENABLE); c++) tick();
        tick();
        tick();
        PRESETn = 1'b0;
        tick();
        check_reset_outputs("rst_access");
        PRESETn = 1'b1;
        last = 1;
        ready_mode = 0;
        drain("rst_restart");

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            round(m, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        end

`ifdef APB_TIMEOUT_EN
        // Stuck slave: abort after four ACCESS cycles with an error completion
        tick();
        ready_mode = 2;
        issue(1, 1'b1, 32'h40, 32'h1234);
        q.push_back('{1, 1'b1, 32'h40, 32'h1234, 32'h0, 1'b1});
        last = 1;
        acc = 0;
        for (int c = 0; c < 50 && req_done == 0; c++) begin
            tick();
            if (PSEL && PENABLE) acc++;
        end
        chk("timeout_access_cycles", 32'(acc), 32'h4);
        chk("timeout_idle", 32'(PSEL), 32'h0);
        ready_mode = 0;
        drain("timeout_complete");
`else
        acc = 0;
`endif

        for (int c = 0; c < 5; c++) tick();
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max PREADY-low cycles per ACCESS before abort (used only with APB_TIMEOUT_EN).
REQ-002 PCLK  in  1  sole clock; all logic on rising edge.
REQ-003 PRESETn  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  2  per-requester transfer request; bit i = requester i.
REQ-005 req_write  in  2  per-requester direction, 1 = write.
REQ-006 req_addr  in  64  {addr1, addr0}, 32 bits each.
REQ-007 req_wdata  in  64  {wdata1, wdata0}, 32 bits each.
REQ-008 req_done  out  2  one-cycle completion pulse, bit i = requester i.
REQ-009 req_rdata  out  32  read data, valid while any req_done bit is high.
REQ-010 req_err  out  1  error flag, valid while any req_done bit is high.
REQ-011 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-012 PADDR, PWDATA  out  32 each  APB address and write data.
REQ-013 PRDATA  in  32  APB read data.
REQ-014 PREADY  in  1  APB slave ready.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP and ACCESS only.
REQ-016 In IDLE with any eligible req_valid bit set, the arbiter SHALL grant one requester, register its write/addr/wdata onto PWRITE/PADDR/PWDATA and enter SETUP at the next edge.
REQ-017 A requester SHALL be ineligible in IDLE during the cycle its req_done bit is high.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, grant goes to the requester not most recently granted; a single request is granted immediately.
REQ-019 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then enter ACCESS.
REQ-020 ACCESS SHALL drive PSEL=1, PENABLE=1 with PADDR/PWRITE/PWDATA held stable until completion.
REQ-021 On an edge with PREADY=1 in ACCESS: FSM -> IDLE; PSEL, PENABLE -> 0; granted req_done bit pulses high for the following cycle; req_rdata = PRDATA for reads, 0 for writes; req_err=0.
REQ-022 Minimum latency SHALL be: req_valid sampled at edge 0, SETUP cycle 1, ACCESS cycle 2, req_done at cycle 3 with zero wait states.
REQ-023 Requesters SHALL hold req_valid and payload until their req_done pulse; changes before done are ignored once granted.
REQ-024 req_done bits SHALL be mutually exclusive and never high in consecutive cycles for the same requester.
REQ-025 The round-robin pointer SHALL update at grant time.

Reset
REQ-026 With PRESETn=0 at an edge: state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_done, req_rdata, req_err = 0; pointer set so requester 0 wins the first contention.
REQ-027 Reset during SETUP or ACCESS SHALL abandon the transfer with no req_done pulse.

Configuration
REQ-028 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0; when it reaches TIMEOUT_CYCLES the transfer SHALL abort as in REQ-021 but with req_err=1 and req_rdata=0; counter clears on entry to SETUP.
REQ-029 Without APB_TIMEOUT_EN, no counter SHALL exist, ACCESS SHALL wait indefinitely, and req_err SHALL be constant 0.

Structure
REQ-030 Package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS), ADDR_W=32, DATA_W=32 and NUM_REQ=2.
REQ-031 Sub-module rr_arbiter SHALL implement the 2-way round-robin grant and pointer; apb_arbiter SHALL hold FSM, payload registers and timeout.

Verification
REQ-032 Requester 0 write addr 0x10 data 0xA5A5A5A5, PREADY=1 -> PSEL at cycle 1, PENABLE at cycle 2, req_done=2'b01 at cycle 3, req_err=0.
REQ-033 Both request at once after reset (r0 read 0x4, r1 read 0x8, PRDATA=0x11/0x22) -> r0 served first with rdata 0x11, then r1 with 0x22; with both held, grants alternate 0,1,0,1.
REQ-034 PREADY held low 3 ACCESS cycles -> PADDR/PWDATA/PSEL/PENABLE stable throughout, req_done one cycle after PREADY rises.
REQ-035 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, req_done pulse with req_err=1, req_rdata=0, FSM IDLE.
REQ-036 PRESETn=0 asserted in ACCESS -> next edge all outputs 0, no req_done; after release, pending request restarts from SETUP.
